// File: rtl/dest_reg_pipe.sv
// Destination-register pipeline (EX/MEM/WB) with operand forwarding selects,
// load-use stall request and register-file write port derivation.
module dest_reg_pipe #(
    parameter int               REG_W    = 5,
    parameter logic [REG_W-1:0] ZERO_REG = '0
) (
    input  logic             Clk,
    input  logic             Rst_n,
    input  logic [REG_W-1:0] id_dest,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             flush,
    output logic             stall,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [REG_W-1:0] ex_dest,
    output logic [REG_W-1:0] mem_dest,
    output logic [REG_W-1:0] wb_dest,
    output logic             wb_reg_write
);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic [REG_W-1:0] r_ex_dest;
    logic             r_ex_reg_write;
    logic             r_ex_mem_read;
    logic [REG_W-1:0] r_ex_rs;
    logic [REG_W-1:0] r_ex_rt;

    logic [REG_W-1:0] r_mem_dest;
    logic             r_mem_reg_write;
    logic             r_mem_mem_read;

    logic [REG_W-1:0] r_wb_dest;
    logic             r_wb_reg_write;

    logic             w_hz;
    logic             w_ex_bubble;
    logic             w_mem_fwd_ok;
    logic             w_wb_fwd_ok;

    // Load-use: a load in EX whose result the decode instruction needs next cycle.
    assign w_hz = r_ex_mem_read && r_ex_reg_write && (r_ex_dest != ZERO_REG) &&
                  (((r_ex_dest == id_rs) && id_uses_rs) ||
                   ((r_ex_dest == id_rt) && id_uses_rt));

    assign stall       = w_hz && !flush;
    assign w_ex_bubble = stall || flush;

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            r_ex_dest       <= '0;
            r_ex_reg_write  <= 1'b0;
            r_ex_mem_read   <= 1'b0;
            r_ex_rs         <= '0;
            r_ex_rt         <= '0;
            r_mem_dest      <= '0;
            r_mem_reg_write <= 1'b0;
            r_mem_mem_read  <= 1'b0;
            r_wb_dest       <= '0;
            r_wb_reg_write  <= 1'b0;
        end else begin
            r_wb_dest       <= r_mem_dest;
            r_wb_reg_write  <= r_mem_reg_write;
            r_mem_dest      <= r_ex_dest;
            r_mem_reg_write <= r_ex_reg_write;
            r_mem_mem_read  <= r_ex_mem_read;
            if (w_ex_bubble) begin
                r_ex_dest      <= '0;
                r_ex_reg_write <= 1'b0;
                r_ex_mem_read  <= 1'b0;
                r_ex_rs        <= '0;
                r_ex_rt        <= '0;
            end else begin
                r_ex_dest      <= id_dest;
                r_ex_reg_write <= id_reg_write;
                r_ex_mem_read  <= id_mem_read;
                r_ex_rs        <= id_rs;
                r_ex_rt        <= id_rt;
            end
        end
    end

    // A load sitting in MEM has no data yet, so it is never a MEM-stage source.
    assign w_mem_fwd_ok = r_mem_reg_write && !r_mem_mem_read && (r_mem_dest != ZERO_REG);
    assign w_wb_fwd_ok  = r_wb_reg_write && (r_wb_dest != ZERO_REG);

    always_comb begin
        fwd_a = FWD_RF;
        if (w_mem_fwd_ok && (r_mem_dest == r_ex_rs)) begin
            fwd_a = FWD_MEM;
        end else if (w_wb_fwd_ok && (r_wb_dest == r_ex_rs)) begin
            fwd_a = FWD_WB;
        end
    end

    always_comb begin
        fwd_b = FWD_RF;
        if (w_mem_fwd_ok && (r_mem_dest == r_ex_rt)) begin
            fwd_b = FWD_MEM;
        end else if (w_wb_fwd_ok && (r_wb_dest == r_ex_rt)) begin
            fwd_b = FWD_WB;
        end
    end

    assign ex_dest      = r_ex_dest;
    assign mem_dest     = r_mem_dest;
    assign wb_dest      = r_wb_dest;
    assign wb_reg_write = w_wb_fwd_ok;

endmodule

// File: tb/tb_dest_reg_pipe.sv
// Directed-vector bench for dest_reg_pipe: each row drives one cycle of decode
// inputs and carries the hand-derived outputs expected before the next edge.
module tb_dest_reg_pipe;

    logic       Clk = 1'b0;
    logic       Rst_n;
    logic [4:0] id_dest, id_rs, id_rt;
    logic       id_reg_write, id_mem_read, id_uses_rs, id_uses_rt, flush;
    logic       stall, wb_reg_write;
    logic [1:0] fwd_a, fwd_b;
    logic [4:0] ex_dest, mem_dest, wb_dest;

    dest_reg_pipe #(.REG_W(5), .ZERO_REG(5'd0)) dut (
        .Clk(Clk), .Rst_n(Rst_n),
        .id_dest(id_dest), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
        .flush(flush), .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .ex_dest(ex_dest), .mem_dest(mem_dest), .wb_dest(wb_dest),
        .wb_reg_write(wb_reg_write)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic       rst_n;
        logic [4:0] dest;
        logic       rw, mr;
        logic [4:0] rs, rt;
        logic       urs, urt, fl;
        logic       e_stall;
        logic [1:0] e_fa, e_fb;
        logic [4:0] e_ex, e_mem, e_wb;
        logic       e_wbw;
    } row_t;

    typedef struct {
        int         idx;
        logic       stall;
        logic [1:0] fa, fb;
        logic [4:0] ex, mem, wb;
        logic       wbw;
    } exp_t;

    row_t rows[$];
    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    task automatic v(input logic rst_n, input logic [4:0] dest, input logic rw, input logic mr,
                     input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                     input logic fl, input logic e_stall, input logic [1:0] e_fa,
                     input logic [1:0] e_fb, input logic [4:0] e_ex, input logic [4:0] e_mem,
                     input logic [4:0] e_wb, input logic e_wbw);
        row_t r;
        r = '{rst_n, dest, rw, mr, rs, rt, urs, urt, fl,
              e_stall, e_fa, e_fb, e_ex, e_mem, e_wb, e_wbw};
        rows.push_back(r);
    endtask

    task automatic chk(input string name, input int idx, input logic [4:0] act,
                       input logic [4:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s row=%0d actual=%0d required=%0d", name, idx, act, req);
        end
    endtask

    // Monitor: outputs are settled mid-cycle, compared against the oldest expectation.
    always @(negedge Clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            chk("stall",        e.idx, {4'd0, stall},        {4'd0, e.stall});
            chk("fwd_a",        e.idx, {3'd0, fwd_a},        {3'd0, e.fa});
            chk("fwd_b",        e.idx, {3'd0, fwd_b},        {3'd0, e.fb});
            chk("ex_dest",      e.idx, ex_dest,              e.ex);
            chk("mem_dest",     e.idx, mem_dest,             e.mem);
            chk("wb_dest",      e.idx, wb_dest,              e.wb);
            chk("wb_reg_write", e.idx, {4'd0, wb_reg_write}, {4'd0, e.wbw});
        end
    end

    initial begin
        //  rst dest rw mr rs  rt  urs urt fl | stall fa    fb    ex  mem wb  wbw
        // idle after reset
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  0,  0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  0,  0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  0,  0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  0,  0,  0);
        // ADD r3, then consumer of r3 -> MEM forward on A
        v(1, 3,  1, 0, 1,  2,  1, 1, 0,   0, 2'b00, 2'b00, 0,  0,  0,  0);
        v(1, 6,  1, 0, 3,  4,  1, 1, 0,   0, 2'b00, 2'b00, 3,  0,  0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b01, 2'b00, 6,  3,  0,  0);
        // producer r5, independent, consumer rt=5 -> WB forward on B
        v(1, 5,  1, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  6,  3,  1);
        v(1, 8,  1, 0, 9,  10, 1, 1, 0,   0, 2'b00, 2'b00, 5,  0,  6,  1);
        v(1, 11, 1, 0, 12, 5,  1, 1, 0,   0, 2'b00, 2'b00, 8,  5,  0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b10, 11, 8,  5,  1);
        // LW r7, consumer rs=7 -> one-cycle stall, then WB forward
        v(1, 7,  1, 1, 2,  7,  1, 0, 0,   0, 2'b00, 2'b00, 0,  11, 8,  1);
        v(1, 13, 1, 0, 7,  1,  1, 1, 0,   1, 2'b00, 2'b00, 7,  0,  11, 1);
        v(1, 13, 1, 0, 7,  1,  1, 1, 0,   0, 2'b00, 2'b00, 0,  7,  0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b10, 2'b00, 13, 0,  7,  1);
        // JAL r31, write to r0, consumer of r0
        v(1, 31, 1, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  13, 0,  0);
        v(1, 0,  1, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 31, 0,  13, 1);
        v(1, 14, 1, 0, 0,  0,  1, 1, 0,   0, 2'b00, 2'b00, 0,  31, 0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 14, 0,  31, 1);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  14, 0,  0);
        // LW r9, consumer with flush -> no stall, bubble
        v(1, 9,  1, 1, 3,  9,  1, 0, 0,   0, 2'b00, 2'b00, 0,  0,  14, 1);
        v(1, 15, 1, 0, 0,  9,  0, 1, 1,   0, 2'b00, 2'b00, 9,  0,  0,  0);
        v(1, 16, 1, 0, 9,  0,  1, 0, 0,   0, 2'b00, 2'b00, 0,  9,  0,  0);
        // back-to-back load-use stalls
        v(1, 10, 1, 1, 1,  10, 1, 0, 0,   0, 2'b10, 2'b00, 16, 0,  9,  1);
        v(1, 12, 1, 1, 10, 12, 1, 0, 0,   1, 2'b00, 2'b00, 10, 16, 0,  0);
        v(1, 12, 1, 1, 10, 12, 1, 0, 0,   0, 2'b00, 2'b00, 0,  10, 16, 1);
        v(1, 17, 1, 0, 0,  12, 0, 1, 0,   1, 2'b10, 2'b00, 12, 0,  10, 1);
        v(1, 17, 1, 0, 0,  12, 0, 1, 0,   0, 2'b00, 2'b00, 0,  12, 0,  0);
        v(1, 18, 1, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b10, 17, 0,  12, 1);
        // MEM on A and WB on B simultaneously
        v(1, 19, 1, 0, 18, 17, 1, 1, 0,   0, 2'b00, 2'b00, 18, 17, 0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b01, 2'b10, 19, 18, 17, 1);
        // same dest in MEM and WB -> MEM wins
        v(1, 20, 1, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  19, 18, 1);
        v(1, 20, 1, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 20, 0,  19, 1);
        v(1, 21, 1, 0, 20, 20, 1, 1, 0,   0, 2'b00, 2'b00, 20, 20, 0,  0);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b01, 2'b01, 21, 20, 20, 1);
        // load in MEM matching EX.rs without a declared use -> no MEM forward
        v(1, 22, 1, 1, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  21, 20, 1);
        v(1, 23, 1, 0, 22, 0,  0, 0, 0,   0, 2'b00, 2'b00, 22, 0,  21, 1);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 23, 22, 0,  0);
        // reset mid-stream discards in-flight entries
        v(0, 24, 1, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  23, 22, 1);
        v(1, 0,  0, 0, 0,  0,  0, 0, 0,   0, 2'b00, 2'b00, 0,  0,  0,  0);

        Rst_n = 1'b0;
        id_dest = '0; id_rs = '0; id_rt = '0;
        id_reg_write = 1'b0; id_mem_read = 1'b0;
        id_uses_rs = 1'b0; id_uses_rt = 1'b0; flush = 1'b0;
        repeat (2) @(posedge Clk);

        for (int i = 0; i < rows.size(); i++) begin
            exp_t e;
            @(posedge Clk);
            #1;
            Rst_n        = rows[i].rst_n;
            id_dest      = rows[i].dest;
            id_reg_write = rows[i].rw;
            id_mem_read  = rows[i].mr;
            id_rs        = rows[i].rs;
            id_rt        = rows[i].rt;
            id_uses_rs   = rows[i].urs;
            id_uses_rt   = rows[i].urt;
            flush        = rows[i].fl;
            e = '{i, rows[i].e_stall, rows[i].e_fa, rows[i].e_fb,
                  rows[i].e_ex, rows[i].e_mem, rows[i].e_wb, rows[i].e_wbw};
            sb.push_back(e);
        end

        @(posedge Clk);
        @(negedge Clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain actual=%0d required=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
